// File: rtl/adc_oversampler.sv
// adc_oversampler: averages 2^OSR_LOG2 SAR ADC conversions into one rounded, saturated 12-bit result.
// Latency: st_conv one cycle after start is accepted; avg_valid two cycles after the last sample's done_edge.
// Backpressure: none; start while busy is dropped, and a conversion that never completes times out.
//
// Ports:
//   clk, rst          - single clock, synchronous active-high reset
//   start             - request one averaged measurement (ignored while busy)
//   st_conv           - one-cycle start-of-conversion pulse to the ADC
//   adc_done, result  - ADC completion level (asynchronous) and its 12-bit result
//   avg_out/avg_valid - rounded average and its one-cycle valid pulse
//   busy              - high whenever the FSM is not idle
//   timeout_err       - sticky abort flag, cleared by the next accepted start
module adc_oversampler #(
  parameter int OSR_LOG2       = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        st_conv,
  input  logic        adc_done,
  input  logic [11:0] result,
  output logic [11:0] avg_out,
  output logic        avg_valid,
  output logic        busy,
  output logic        timeout_err
);

  localparam int AW = 12 + OSR_LOG2;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = OSR_LOG2 + 1;

  localparam logic [CW-1:0] LAST_SAMPLE = CW'((1 << OSR_LOG2) - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
  // Half an LSB of the output; shifting 1 down by one yields zero when no averaging is done.
  localparam logic [AW:0]   ROUND_TERM  = (AW + 1)'((1 << OSR_LOG2) >> 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_TRIG = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]    state;
  logic [AW-1:0] acc;
  logic [CW-1:0] smp_cnt;
  logic [TW-1:0] to_cnt;
  logic [11:0]   cap;
  logic          sync_q1, sync_q2, sync_q3;
  logic          done_edge;

  logic [AW-1:0] acc_next;
  logic [AW:0]   rounded;
  logic [AW:0]   scaled;
  logic [11:0]   avg_calc;

  // Two flops bring adc_done into the clk domain; the third remembers the previous level.
  assign done_edge = sync_q2 & ~sync_q3;

  // The accumulator holds at most 2^OSR_LOG2 full-scale samples, so AW bits never wrap.
  assign acc_next = acc + AW'(cap);
  assign rounded  = {1'b0, acc_next} + ROUND_TERM;
  assign scaled   = rounded >> OSR_LOG2;
  assign avg_calc = (scaled > (AW + 1)'(12'hFFF)) ? 12'hFFF : scaled[11:0];

  assign st_conv   = (state == S_TRIG);
  assign avg_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      acc         <= '0;
      smp_cnt     <= '0;
      to_cnt      <= '0;
      cap         <= '0;
      avg_out     <= '0;
      timeout_err <= 1'b0;
      sync_q1     <= 1'b0;
      sync_q2     <= 1'b0;
      sync_q3     <= 1'b0;
    end else begin
      sync_q1 <= adc_done;
      sync_q2 <= sync_q1;
      sync_q3 <= sync_q2;

      case (state)
        S_IDLE: begin
          if (start) begin
            state       <= S_TRIG;
            acc         <= '0;
            smp_cnt     <= '0;
            to_cnt      <= '0;
            timeout_err <= 1'b0;
          end
        end
        S_TRIG: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (done_edge) begin
            cap   <= result;
            state <= S_ACC;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        S_ACC: begin
          acc <= acc_next;
          if (smp_cnt == LAST_SAMPLE) begin
            // Registering the average here makes avg_out valid in the same cycle as avg_valid.
            avg_out <= avg_calc;
            state   <= S_DONE;
          end else begin
            smp_cnt <= smp_cnt + CW'(1);
            state   <= S_TRIG;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_oversampler.sv
module tb_adc_oversampler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, adc_done;
  logic [11:0] result;
  logic        st_conv, avg_valid, busy, timeout_err;
  logic [11:0] avg_out;

  logic        start0, adc_done0;
  logic [11:0] result0;
  logic        st_conv0, avg_valid0, busy0, timeout_err0;
  logic [11:0] avg_out0;

  int total = 0;
  int bad   = 0;
  int st_cnt = 0, av_cnt = 0, overlap = 0;

  always #5 clk = ~clk;

  adc_oversampler #(.OSR_LOG2(2), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .start(start), .st_conv(st_conv),
    .adc_done(adc_done), .result(result), .avg_out(avg_out),
    .avg_valid(avg_valid), .busy(busy), .timeout_err(timeout_err)
  );

  adc_oversampler #(.OSR_LOG2(0), .TIMEOUT_CYCLES(64)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .st_conv(st_conv0),
    .adc_done(adc_done0), .result(result0), .avg_out(avg_out0),
    .avg_valid(avg_valid0), .busy(busy0), .timeout_err(timeout_err0)
  );

  always @(negedge clk) begin
    if (st_conv) st_cnt++;
    if (avg_valid) av_cnt++;
    if (st_conv && avg_valid) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bounded wait for the next st_conv pulse, sampled on falling edges.
  task automatic wait_st(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!st_conv && n < 30);
    chk(tag, {31'd0, st_conv}, 32'd1);
  endtask

  // ADC model: answer a conversion with value v, optionally poking start during WAIT.
  task automatic do_sample(input logic [11:0] v, input bit poke, input bit skip_wait);
    if (!skip_wait) wait_st("st_conv_seen");
    if (poke) begin
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
    end
    @(posedge clk); #1 result = v; adc_done = 1'b1;
    repeat (2) @(posedge clk);
    #1 adc_done = 1'b0;
  endtask

  task automatic wait_avg(input string tag, input logic [11:0] exp);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avg_valid && n < 30);
    chk({tag, "_valid"}, {31'd0, avg_valid}, 32'd1);
    chk({tag, "_avg"}, {20'd0, avg_out}, {20'd0, exp});
  endtask

  task automatic measure4(input string tag, input logic [11:0] v0, input logic [11:0] v1,
                          input logic [11:0] v2, input logic [11:0] v3,
                          input bit poke, input logic [11:0] exp);
    int sc, ac;
    sc = st_cnt;
    ac = av_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(negedge clk);
    chk({tag, "_st_pre"}, {31'd0, st_conv}, 32'd0);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk({tag, "_st_lat1"}, {31'd0, st_conv}, 32'd1);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    chk({tag, "_terr_clr"}, {31'd0, timeout_err}, 32'd0);
    do_sample(v0, poke, 1'b1);
    do_sample(v1, 1'b0, 1'b0);
    do_sample(v2, 1'b0, 1'b0);
    do_sample(v3, 1'b0, 1'b0);
    wait_avg(tag, exp);
    @(negedge clk);
    chk({tag, "_nconv"}, st_cnt - sc, 32'd4);
    chk({tag, "_nvalid"}, av_cnt - ac, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc, ac;
    rst = 1'b1; start = 1'b0; adc_done = 1'b0; result = '0;
    start0 = 1'b0; adc_done0 = 1'b0; result0 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_avg_out", {20'd0, avg_out}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_st_conv", {31'd0, st_conv}, 32'd0);
    chk("rst_avg_valid", {31'd0, avg_valid}, 32'd0);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_avg_out0", {20'd0, avg_out0}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Basic average with rounding: (406+2)>>2.
    measure4("m_100", 12'd100, 12'd101, 12'd102, 12'd103, 1'b0, 12'd102);
    // Full scale: must saturate at 4095 without wrapping.
    measure4("m_sat", 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 1'b0, 12'hFFF);
    // Exact half LSB rounds up: (6+2)>>2.
    measure4("m_half", 12'd0, 12'd2, 12'd2, 12'd2, 1'b0, 12'd2);

    // Timeout: no adc_done; error appears 64 cycles after WAIT entry.
    ac = av_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("to_st_conv", {31'd0, st_conv}, 32'd1);
    repeat (64) @(negedge clk);
    chk("to_not_yet", {31'd0, timeout_err}, 32'd0);
    chk("to_busy_yet", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("to_err", {31'd0, timeout_err}, 32'd1);
    chk("to_idle", {31'd0, busy}, 32'd0);
    chk("to_avg_hold", {20'd0, avg_out}, 32'd2);
    repeat (5) @(negedge clk);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    chk("to_no_valid", av_cnt - ac, 32'd0);

    // start during WAIT is ignored; also clears the sticky error. (21+2)>>2.
    measure4("m_poke", 12'd5, 12'd5, 12'd5, 12'd6, 1'b1, 12'd5);

    // adc_done while idle: nothing happens.
    sc = st_cnt; ac = av_cnt;
    @(posedge clk); #1 result = 12'd999; adc_done = 1'b1;
    repeat (3) @(posedge clk);
    #1 adc_done = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_done_conv", st_cnt - sc, 32'd0);
    chk("idle_done_valid", av_cnt - ac, 32'd0);
    chk("idle_done_busy", {31'd0, busy}, 32'd0);
    chk("idle_done_hold", {20'd0, avg_out}, 32'd5);

    // Reset during the second sample.
    ac = av_cnt;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("rm_st_conv", {31'd0, st_conv}, 32'd1);
    do_sample(12'd500, 1'b0, 1'b1);
    wait_st("rm_st_conv2");
    @(posedge clk); #1 result = 12'd600; adc_done = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rm_busy", {31'd0, busy}, 32'd0);
    chk("rm_st_conv0", {31'd0, st_conv}, 32'd0);
    chk("rm_avg_valid", {31'd0, avg_valid}, 32'd0);
    chk("rm_terr", {31'd0, timeout_err}, 32'd0);
    chk("rm_avg_out", {20'd0, avg_out}, 32'd0);
    sc = st_cnt;
    repeat (2) @(posedge clk);
    #1 adc_done = 1'b0;
    repeat (8) @(negedge clk);
    chk("rm_late_edge_conv", st_cnt - sc, 32'd0);
    chk("rm_late_edge_valid", av_cnt - ac, 32'd0);
    chk("rm_late_edge_busy", {31'd0, busy}, 32'd0);
    // Fresh measurement after the abort: (100+2)>>2.
    measure4("m_after_rst", 12'd10, 12'd20, 12'd30, 12'd40, 1'b0, 12'd25);

    // OSR_LOG2=0: single result passes through, avg_valid 2 cycles after done_edge.
    @(posedge clk); #1 start0 = 1'b1;
    @(posedge clk); #1 start0 = 1'b0;
    @(negedge clk);
    chk("osr0_st_conv", {31'd0, st_conv0}, 32'd1);
    @(posedge clk); #1 result0 = 12'h5A5; adc_done0 = 1'b1;
    repeat (4) @(negedge clk);
    chk("osr0_valid_early", {31'd0, avg_valid0}, 32'd0);
    @(negedge clk);
    chk("osr0_valid", {31'd0, avg_valid0}, 32'd1);
    chk("osr0_avg", {20'd0, avg_out0}, 32'h5A5);
    @(posedge clk); #1 adc_done0 = 1'b0;
    @(negedge clk);
    chk("osr0_idle", {31'd0, busy0}, 32'd0);

    chk("no_overlap", overlap, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_oversampler.md
ADC_OVERSAMPLER -- requirements
Module: adc_oversampler

Interface
REQ-001 SHALL provide parameter OSR_LOG2, default 2, meaning log2 of the samples averaged per measurement (legal 0..4).
REQ-002 SHALL provide parameter TIMEOUT_CYCLES, default 64, meaning the maximum clk cycles to wait for one conversion before aborting.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL provide port start  input  1  request one averaged measurement, sampled each clk.
REQ-006 SHALL provide port st_conv  output  1  one-cycle start-of-conversion pulse to the SAR ADC FSM.
REQ-007 SHALL provide port adc_done  input  1  ADC conversion-complete level, asynchronous to clk.
REQ-008 SHALL provide port result  input  12  ADC conversion result, stable while adc_done is high.
REQ-009 SHALL provide port avg_out  output  12  rounded average of the last completed measurement.
REQ-010 SHALL provide port avg_valid  output  1  one-cycle pulse marking a new avg_out.
REQ-011 SHALL provide port busy  output  1  high whenever the state is not IDLE.
REQ-012 SHALL provide port timeout_err  output  1  sticky abort flag, cleared by the next accepted start or by rst.

Function
REQ-013 SHALL pass adc_done through a 2-flop synchronizer, then rising-edge detect it into done_edge (done_edge valid 2-3 cycles after the adc_done rise).
REQ-014 SHALL implement states IDLE, TRIG, WAIT, ACC, DONE.
REQ-015 IDLE: start=1 -> TRIG; accumulator, sample counter and timeout counter cleared; timeout_err cleared.
REQ-016 TRIG: st_conv=1 for exactly this one cycle -> WAIT; timeout counter cleared.
REQ-017 WAIT: done_edge=1 -> ACC with result captured the same cycle; else timeout counter increments.
REQ-018 WAIT: timeout counter reaching TIMEOUT_CYCLES-1 without done_edge -> IDLE, timeout_err=1, no avg_valid.
REQ-019 ACC: accumulator += captured result; if sample count = 2^OSR_LOG2-1 -> DONE, else sample count +1 -> TRIG.
REQ-020 Accumulator width SHALL be 12+OSR_LOG2 bits; it SHALL never overflow.
REQ-021 DONE: avg_out <= (acc + 2^(OSR_LOG2-1)) >> OSR_LOG2, saturated to 4095; avg_valid=1 for this one cycle -> IDLE.
REQ-022 OSR_LOG2=0: no rounding term; avg_out equals the single result.
REQ-023 Latency: start accepted at cycle 0 gives st_conv at cycle 1; avg_valid asserts 2 cycles after the done_edge of the last sample.
REQ-024 start while busy=1 SHALL be ignored, not queued.
REQ-025 done_edge outside WAIT SHALL be ignored; it is not stored.
REQ-026 avg_out SHALL hold its value between avg_valid pulses and after a timeout.
REQ-027 st_conv and avg_valid SHALL never both be high in the same cycle.

Reset
REQ-028 rst=1 SHALL force IDLE and clear all counters, the accumulator and the synchronizer flops; st_conv=0, avg_valid=0, busy=0, timeout_err=0, avg_out=0.
REQ-029 rst SHALL take priority over start in the same cycle.
REQ-030 rst mid-measurement SHALL abort it with no avg_valid; a later adc_done edge SHALL be ignored until a new start is accepted.

Verification
REQ-031 OSR_LOG2=2, ADC model returns 100,101,102,103 -> 4 st_conv pulses, one avg_valid, avg_out=102 (406+2>>2).
REQ-032 OSR_LOG2=2, all results 4095 -> avg_out=4095 (saturation), no accumulator wrap.
REQ-033 OSR_LOG2=0, result 0x5A5 -> avg_out=0x5A5 two cycles after the done_edge.
REQ-034 adc_done never rises, TIMEOUT_CYCLES=64 -> timeout_err=1 64 cycles after WAIT entry, busy=0, avg_out unchanged.
REQ-035 start pulsed again during WAIT, and adc_done pulsed while IDLE -> no extra st_conv, no avg_valid.
REQ-036 rst asserted during the second sample -> all outputs at reset values next cycle; a fresh start then completes a normal 4-sample average.
